bin16_to_bcd_seq: RTL and testbench
===================================

# bin16_to_bcd_seq

Multi-cycle binary-to-BCD converter for the calculator datapath. It sits directly downstream of the 8-bit repeated-addition multiplier. It takes that unit's 16-bit binary product and converts it to five packed BCD digits for the display/BCD result path, using shift-and-add-3 (double dabble) at one bit per clock. It also reports the significant digit count and a leading-zero blanking mask, so the display driver needs no extra logic.

## Interface
- No parameters; widths fixed (16-bit in, 5 BCD digits out).
- Reset is `rst`, asynchronous, active-high; clock is `clk`.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous active-high reset
- `start`  input  1  sampled each rising edge; high = capture `bin` and begin conversion
- `bin`  input  16  unsigned binary value (multiplier `product`); sampled only on the `start` edge
- `bcd`  output  20  packed BCD result; [3:0] = ones, [19:16] = ten-thousands
- `ndigits`  output  3  significant digits in `bcd`, 1..5; value 0 reports 1
- `lz_mask`  output  5  bit i = 1 when digit i is a leading zero to blank; bit 0 always 0
- `busy`  output  1  high while a conversion is in progress
- `done`  output  1  level; high from completion until the next accepted `start`

## Operation
- States:
  - IDLE: after reset, no result yet.
  - SHIFT: iterating.
  - FINISH: one cycle, latches outputs.
  - DONE: result valid, `done`=1.
- Internal registers:
  - 36-bit shift register {bcd_work[19:0], bin_work[15:0]}.
  - 5-bit iteration counter.
- `start` has priority in every state, including SHIFT. On a `start` edge:
  - Shift register is loaded with {20'h00000, bin}.
  - Counter is set to 16.
  - `done`<=0, `busy`<=1, state -> SHIFT.
  - A restart mid-conversion abandons the old conversion.
- SHIFT with counter != 0, each edge:
  - Every BCD nibble of bcd_work >= 5 gets +3.
  - Then the whole 36-bit register shifts left by 1 (zero in).
  - Counter is decremented.
  - Corrections are computed combinationally from the pre-shift value within the same cycle.
- SHIFT with counter == 0: state -> FINISH.
- FINISH:
  - `bcd`<=bcd_work.
  - `ndigits`<=index of the highest non-zero digit + 1, minimum 1.
  - `lz_mask` bit i<=1 for every i >= `ndigits`.
  - `done`<=1, `busy`<=0, state -> DONE.
- DONE: holds all outputs until the next `start`. `start` with `busy`=0 is never ignored.
- Width rules:
  - Max input 65535 fits in 5 digits, so no overflow output exists.
  - Nibble correction is 4-bit. A value 5..9 + 3 stays in 8..12, so no carry out of the nibble.
- `bcd`, `ndigits` and `lz_mask` change only in FINISH. They keep the previous result while a new conversion runs; consumers qualify them with `done`.

## Timing
- Reset values: `bcd`=20'h00000, `ndigits`=3'd1, `lz_mask`=5'b11110, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset asserted mid-conversion: all of the above take effect immediately (async). The conversion is lost and no `done` is produced.
- Latency, with `start` sampled at edge k:
  - `busy`=1 after edge k.
  - Iterations on edges k+1..k+16.
  - FINISH on edge k+17.
  - Outputs valid and `done`=1, `busy`=0 after edge k+18.
  - Fixed 18 cycles, independent of data.
- Connecting to the multiplier: drive `start` from a rising-edge detect of the multiplier's `done`, and `bin` from its `product`. `bin` need not be held after the `start` edge.
- `start` held high continuously: conversion restarts every edge and never completes. This is legal; `done` stays 0.
- `start` on the same edge FINISH would occur: `start` wins, and `done` stays 0.

## Test plan
- Reset then idle:
  - Response: `bcd`=0x00000, `ndigits`=1, `lz_mask`=5'b11110, `busy`=0, `done`=0.
- `bin`=65025 (255x255 from the multiplier), 1-cycle `start`:
  - `busy` high for exactly 18 cycles.
  - Then `bcd`=0x65025, `ndigits`=5, `lz_mask`=5'b00000, `done`=1 held.
- `bin`=0:
  - `bcd`=0x00000, `ndigits`=1, `lz_mask`=5'b11110.
- `bin`=1000, then `bin`=65535 back-to-back:
  - First result: `bcd`=0x01000, `ndigits`=4, `lz_mask`=5'b10000.
  - Second result: 0x65535, `ndigits`=5.
  - `done` drops the cycle after the second `start`.
  - `bcd` holds 0x01000 until the second FINISH.
- `start` with `bin`=12345, then `start` with `bin`=9 at edge k+7:
  - Only `bcd`=0x00009, `ndigits`=1, `lz_mask`=5'b11110, `done` 18 cycles after the second `start`.
  - 12345 never appears.
- Assert `rst` for 1 cycle at edge k+10 of a conversion of 4321:
  - Outputs return to reset values immediately.
  - No `done` afterward.
  - A subsequent `start` with 4321 gives 0x04321, `ndigits`=4.

Source files
------------

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter.
// Uses shift-and-add-3 at one bit per clock and reports digit count and a leading-zero mask.
module bin16_to_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic [2:0]  ndigits,
    output logic [4:0]  lz_mask,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [35:0] work;
    logic [4:0]  count;
    logic [19:0] bcd_adj;
    logic [2:0]  nd_calc;
    logic [4:0]  lz_calc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start edge overrides whatever the FSM was doing, including a conversion in flight.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT:   if (count == 5'd0) state_next = FINISH;
                FINISH:  state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == SHIFT) || (state == FINISH);
        done = (state == DONE);
    end

    // Add-3 correction from the pre-shift digits; 5..9 + 3 stays within a nibble.
    always_comb begin
        bcd_adj = 20'h00000;
        for (int i = 0; i < 5; i++) begin
            if (work[16 + 4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = work[16 + 4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = work[16 + 4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= 36'd0;
            count <= 5'd0;
        end else if (start) begin
            work  <= {20'h00000, bin};
            count <= 5'd16;
        end else if ((state == SHIFT) && (count != 5'd0)) begin
            work  <= {bcd_adj[18:0], work[15:0], 1'b0};
            count <= count - 5'd1;
        end
    end

    always_comb begin
        nd_calc = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (work[16 + 4*i +: 4] != 4'd0) begin
                nd_calc = 3'(i + 1);
            end
        end
        lz_calc = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            lz_calc[i] = (3'(i) >= nd_calc);
        end
    end

    // Result registers only move in FINISH, so the previous answer survives a new conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd     <= 20'h00000;
            ndigits <= 3'd1;
            lz_mask <= 5'b11110;
        end else if ((state == FINISH) && !start) begin
            bcd     <= work[35:16];
            ndigits <= nd_calc;
            lz_mask <= lz_calc;
        end
    end

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Self-checking bench for bin16_to_bcd_seq: directed table, multi-cycle corner cases
// and random values against an arithmetic decimal-digit model.
module tb_bin16_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [2:0]  ndigits;
    logic [4:0]  lz_mask;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [19:0] lastBcd;

    typedef struct {
        logic [15:0] value;
        logic [19:0] expBcd;
        logic [2:0]  expNd;
        logic [4:0]  expLz;
    } vector_t;

    vector_t vectors[10];

    bin16_to_bcd_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bin(bin),
        .bcd(bcd),
        .ndigits(ndigits),
        .lz_mask(lz_mask),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, then digit count and blanking mask from them.
    function automatic void model(input logic [15:0] v, output logic [19:0] b,
                                  output logic [2:0] nd, output logic [4:0] lz);
        int rem;
        int d;
        rem = int'(v);
        b   = 20'h00000;
        nd  = 3'd1;
        for (int i = 0; i < 5; i++) begin
            d = rem % 10;
            rem = rem / 10;
            b[4*i +: 4] = 4'(d);
            if (d != 0) nd = 3'(i + 1);
        end
        for (int i = 0; i < 5; i++) lz[i] = (i >= int'(nd));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Must be called at a negedge; start is sampled on the next rising edge.
    task automatic applyStimulus(input logic [15:0] v);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 16'($urandom);
    endtask

    // Entered at the negedge right after the accepted start edge.
    task automatic finishCheck(input string name, input logic [19:0] expBcd, input logic [2:0] expNd,
                               input logic [4:0] expLz, input logic [19:0] holdBcd);
        int cnt;
        int holdBad;
        cnt = 0;
        holdBad = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (bcd !== holdBcd || done) holdBad++;
            @(negedge clk);
        end
        checkOutput({name, " busy_cycles"}, 32'(cnt), 32'd18);
        checkOutput({name, " held_prev"}, 32'(holdBad), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd1);
        checkOutput({name, " bcd"}, 32'(bcd), 32'(expBcd));
        checkOutput({name, " ndigits"}, 32'(ndigits), 32'(expNd));
        checkOutput({name, " lz_mask"}, 32'(lz_mask), 32'(expLz));
        lastBcd = expBcd;
    endtask

    task automatic runConversion(input string name, input logic [15:0] v, input logic [19:0] expBcd,
                                 input logic [2:0] expNd, input logic [4:0] expLz);
        applyStimulus(v);
        finishCheck(name, expBcd, expNd, expLz, lastBcd);
    endtask

    initial begin
        logic [19:0] mb;
        logic [2:0]  mn;
        logic [4:0]  ml;
        logic [15:0] rv;
        int bad;

        vectors[0] = '{16'd0,     20'h00000, 3'd1, 5'b11110};
        vectors[1] = '{16'd65025, 20'h65025, 3'd5, 5'b00000};
        vectors[2] = '{16'd65535, 20'h65535, 3'd5, 5'b00000};
        vectors[3] = '{16'd100,   20'h00100, 3'd3, 5'b11000};
        vectors[4] = '{16'd9,     20'h00009, 3'd1, 5'b11110};
        vectors[5] = '{16'd10,    20'h00010, 3'd2, 5'b11100};
        vectors[6] = '{16'd99,    20'h00099, 3'd2, 5'b11100};
        vectors[7] = '{16'd10000, 20'h10000, 3'd5, 5'b00000};
        vectors[8] = '{16'd4321,  20'h04321, 3'd4, 5'b10000};
        vectors[9] = '{16'd59999, 20'h59999, 3'd5, 5'b00000};

        rst = 1'b1;
        start = 1'b0;
        bin = 16'd0;
        lastBcd = 20'h00000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset bcd", 32'(bcd), 32'h00000);
        checkOutput("reset ndigits", 32'(ndigits), 32'd1);
        checkOutput("reset lz_mask", 32'(lz_mask), 32'b11110);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);

        foreach (vectors[i]) begin
            runConversion($sformatf("vec%0d", i), vectors[i].value, vectors[i].expBcd,
                          vectors[i].expNd, vectors[i].expLz);
        end

        // done is a level that holds while idle
        repeat (5) @(negedge clk);
        checkOutput("done hold", 32'(done), 32'd1);
        checkOutput("bcd hold", 32'(bcd), 32'(lastBcd));

        // back-to-back 1000 then 65535
        runConversion("b2b_first", 16'd1000, 20'h01000, 3'd4, 5'b10000);
        applyStimulus(16'd65535);
        checkOutput("b2b done_drop", 32'(done), 32'd0);
        checkOutput("b2b busy", 32'(busy), 32'd1);
        finishCheck("b2b_second", 20'h65535, 3'd5, 5'b00000, 20'h01000);

        // restart at k+7 abandons 12345
        applyStimulus(16'd12345);
        repeat (6) @(negedge clk);
        applyStimulus(16'd9);
        finishCheck("restart", 20'h00009, 3'd1, 5'b11110, 20'h65535);

        // start on the FINISH edge wins
        applyStimulus(16'd5);
        repeat (17) @(negedge clk);
        applyStimulus(16'd77);
        checkOutput("finish_edge done", 32'(done), 32'd0);
        finishCheck("finish_edge", 20'h00077, 3'd2, 5'b11100, 20'h00009);

        // start held high never completes
        bad = 0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bin = 16'(i * 1000 + 7);
            @(negedge clk);
            if (!busy || done) bad++;
        end
        start = 1'b0;
        checkOutput("held_start never_done", 32'(bad), 32'd0);
        finishCheck("held_start", 20'h29007, 3'd5, 5'b00000, 20'h00077);

        // async reset at edge k+10 of 4321
        applyStimulus(16'd4321);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset bcd", 32'(bcd), 32'h00000);
        checkOutput("midreset ndigits", 32'(ndigits), 32'd1);
        checkOutput("midreset lz_mask", 32'(lz_mask), 32'b11110);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        checkOutput("midreset no_done", 32'(bad), 32'd0);
        lastBcd = 20'h00000;
        runConversion("after_reset", 16'd4321, 20'h04321, 3'd4, 5'b10000);

        // random values against the model
        for (int i = 0; i < 40; i++) begin
            rv = 16'($urandom);
            if (i % 4 == 1) rv = 16'($urandom_range(0, 999));
            model(rv, mb, mn, ml);
            runConversion($sformatf("rand%0d_%0d", i, rv), rv, mb, mn, ml);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
